// File: rtl/enc8b10b_pkg.sv
// Shared definitions for the 8b/10b transmit encoder.
//   - RD- column lookups for the 5b/6b and 3b/4b sub-blocks. The RD+ form of an
//     entry is its bitwise complement wherever the entry has two forms.
//   - Legal control-character check.
//   - Running-disparity and filler constants.
package enc8b10b_pkg;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic       RD_NEG = 1'b0;
    localparam logic       RD_POS = 1'b1;

    // 6b code abcdei, RD- column
    function automatic logic [5:0] enc_5b6b_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 4b code fghj, RD- column, primary (P7) form for x.7
    function automatic logic [3:0] enc_3b4b_neg(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;
            3'd1: c = 4'b1001;
            3'd2: c = 4'b0101;
            3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;
            3'd5: c = 4'b1010;
            3'd6: c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // K28.0-K28.7 plus K23.7, K27.7, K29.7, K30.7
    function automatic logic is_legal_k(input logic [7:0] d);
        return (d[4:0] == 5'd28) ||
               (d == 8'hF7) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
    endfunction

endpackage

// File: rtl/enc8b10b_core.sv
// Combinational 8b/10b symbol encoder.
//   data_i    : byte, [4:0]=EDCBA, [7:5]=HGF
//   k_i       : control-character request
//   rd_i      : running disparity before this symbol (1 = RD+)
//   symbol_o  : [9:4]=abcdei, [3:0]=fghj
//   rd_next_o : running disparity after this symbol
//   k_err_o   : K requested for a byte that has no legal K code
module enc8b10b_core
    import enc8b10b_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       k_i,
    input  logic       rd_i,
    output logic [9:0] symbol_o,
    output logic       rd_next_o,
    output logic       k_err_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k28;
    logic [5:0] six_n;
    logic [5:0] six;
    logic       unbal6;
    logic       rd6;
    logic       use_a7;
    logic [3:0] four_n;
    logic [3:0] four;
    logic       unbal4;

    always_comb begin
        x      = data_i[4:0];
        y      = data_i[7:5];
        k_ok   = k_i & is_legal_k(data_i);
        k_err_o = k_i & ~k_ok;
        k28    = k_ok & (x == 5'd28);

        six_n  = k28 ? 6'b001111 : enc_5b6b_neg(x);
        unbal6 = ($countones(six_n) != 3);
        // D.7 is balanced but still has a distinct RD+ form
        six    = (rd_i & (unbal6 | (x == 5'd7))) ? ~six_n : six_n;
        rd6    = rd_i ^ unbal6;

        // A7 avoids a run of five equal bits across the 6b/4b boundary
        use_a7 = (y == 3'd7) &
                 (k_ok |
                  (~rd6 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
                  ( rd6 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));
        four_n = use_a7 ? 4'b0111 : enc_3b4b_neg(y);
        unbal4 = ($countones(four_n) != 2);

        if (k28 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) begin
            // balanced K28 forms take the column opposite to the data code
            four = rd6 ? four_n : ~four_n;
        end else begin
            four = (rd6 & (unbal4 | (y == 3'd3))) ? ~four_n : four_n;
        end

        rd_next_o = rd6 ^ unbal4;
        symbol_o  = {six, four};
    end

endmodule

// File: rtl/encode_8b10b_tx.sv
// Transmit-side 8b/10b encoder with running-disparity tracking.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid / in_ready / in_data / in_k : byte input handshake
//   out_valid / out_ready / out_symbol   : symbol output handshake, a first (bit 9)
//   out_k_err  : symbol was produced for an illegal K request
//   rd_out     : running disparity after the last loaded symbol (1 = RD+)
// Parameters:
//   RD_INIT    : disparity after reset
//   IDLE_FILL  : load K28.5 whenever the output stage is free and no byte is offered
module encode_8b10b_tx
    import enc8b10b_pkg::*;
#(
    parameter bit RD_INIT   = 1'b0,
    parameter bit IDLE_FILL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] out_symbol,
    output logic       out_k_err,
    output logic       rd_out
);

    logic       valid_q, valid_d;
    logic [9:0] sym_q, sym_d;
    logic       kerr_q, kerr_d;
    logic       rd_q, rd_d;

    logic [7:0] enc_data;
    logic       enc_k;
    logic [9:0] enc_sym;
    logic       enc_rd;
    logic       enc_kerr;

    // a real byte always takes priority over the filler
    assign enc_data = in_valid ? in_data : K28_5;
    assign enc_k    = in_valid ? in_k    : 1'b1;

    enc8b10b_core u_core (
        .data_i    (enc_data),
        .k_i       (enc_k),
        .rd_i      (rd_q),
        .symbol_o  (enc_sym),
        .rd_next_o (enc_rd),
        .k_err_o   (enc_kerr)
    );

    assign in_ready = ~valid_q | out_ready;

    always_comb begin
        valid_d = valid_q;
        sym_d   = sym_q;
        kerr_d  = kerr_q;
        rd_d    = rd_q;
        if (in_ready) begin
            if (in_valid || IDLE_FILL) begin
                valid_d = 1'b1;
                sym_d   = enc_sym;
                kerr_d  = enc_kerr;
                rd_d    = enc_rd;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            kerr_q  <= 1'b0;
            rd_q    <= RD_INIT;
        end else begin
            valid_q <= valid_d;
            sym_q   <= sym_d;
            kerr_q  <= kerr_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_symbol = sym_q;
    assign out_k_err  = kerr_q;
    assign rd_out     = rd_q;

endmodule

// File: tb/tb_encode_8b10b_tx.sv
// Bench for encode_8b10b_tx. Three instances share stimulus:
//   0: RD_INIT=0, IDLE_FILL=0   1: RD_INIT=0, IDLE_FILL=1   2: RD_INIT=1, IDLE_FILL=0
module tb_encode_8b10b_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_k;
    logic       out_ready;

    logic       in_ready_w  [3];
    logic       out_valid_w [3];
    logic [9:0] out_symbol_w[3];
    logic       out_k_err_w [3];
    logic       rd_out_w    [3];

    encode_8b10b_tx #(.RD_INIT(1'b0), .IDLE_FILL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .in_k(in_k), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .out_symbol(out_symbol_w[0]),
        .out_k_err(out_k_err_w[0]), .rd_out(rd_out_w[0]));

    encode_8b10b_tx #(.RD_INIT(1'b0), .IDLE_FILL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .in_k(in_k), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .out_symbol(out_symbol_w[1]),
        .out_k_err(out_k_err_w[1]), .rd_out(rd_out_w[1]));

    encode_8b10b_tx #(.RD_INIT(1'b1), .IDLE_FILL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_data(in_data), .in_k(in_k), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .out_symbol(out_symbol_w[2]),
        .out_k_err(out_k_err_w[2]), .rd_out(rd_out_w[2]));

    // Full code tables, both disparity columns written out
    logic [5:0] six_neg [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] six_pos [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] four_neg[8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] four_pos[8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k28_neg [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k28_pos [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [7:0] k_list  [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic       m_valid[3];
    logic [9:0] m_sym  [3];
    logic       m_kerr [3];
    logic       m_rd   [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void ref_enc(input logic [7:0] d, input logic k, input logic rd,
                                    output logic [9:0] sym, output logic rd_n, output logic kerr);
        int x, y;
        logic legal, rd6;
        logic [5:0] six;
        logic [3:0] four;
        x = int'(d[4:0]);
        y = int'(d[7:5]);
        legal = k && (x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)));
        kerr  = k && !legal;
        if (legal && x == 28) six = rd ? 6'b110000 : 6'b001111;
        else                  six = rd ? six_pos[x] : six_neg[x];
        rd6 = ($countones(six) == 3) ? rd : !rd;
        if (legal && x == 28)
            four = rd6 ? k28_pos[y] : k28_neg[y];
        else if (y == 7 && (legal || (!rd6 && (x == 17 || x == 18 || x == 20)) ||
                                     ( rd6 && (x == 11 || x == 13 || x == 14))))
            four = rd6 ? 4'b1000 : 4'b0111;
        else
            four = rd6 ? four_pos[y] : four_neg[y];
        rd_n = ($countones(four) == 2) ? rd6 : !rd6;
        sym  = {six, four};
    endfunction

    // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic cycle(input logic r_rst, input logic v, input logic [7:0] d,
                         input logic k, input logic r);
        logic [9:0] s;
        logic       rn, ke, rdy;
        rst = r_rst; in_valid = v; in_data = d; in_k = k; out_ready = r;
        #1;
        if (!r_rst)
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("in_ready%0d", i), 32'(in_ready_w[i]), 32'(!m_valid[i] || r));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r_rst) begin
                m_valid[i] = 1'b0; m_sym[i] = '0; m_kerr[i] = 1'b0; m_rd[i] = (i == 2);
            end else begin
                rdy = !m_valid[i] || r;
                if (rdy && v) begin
                    ref_enc(d, k, m_rd[i], s, rn, ke);
                    m_valid[i] = 1'b1; m_sym[i] = s; m_kerr[i] = ke; m_rd[i] = rn;
                end else if (rdy && i == 1) begin
                    ref_enc(8'hBC, 1'b1, m_rd[i], s, rn, ke);
                    m_valid[i] = 1'b1; m_sym[i] = s; m_kerr[i] = ke; m_rd[i] = rn;
                end else if (rdy) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("out_valid%0d", i), 32'(out_valid_w[i]), 32'(m_valid[i]));
            check_eq($sformatf("rd_out%0d", i), 32'(rd_out_w[i]), 32'(m_rd[i]));
            if (m_valid[i] || r_rst) begin
                check_eq($sformatf("out_symbol%0d", i), 32'(out_symbol_w[i]), 32'(m_sym[i]));
                check_eq($sformatf("out_k_err%0d", i), 32'(out_k_err_w[i]), 32'(m_kerr[i]));
            end
        end
        @(negedge clk);
    endtask

    logic [9:0] prev_fill;
    logic [7:0] rd_byte;
    logic       rk;

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0; m_sym[i] = '0; m_kerr[i] = 1'b0; m_rd[i] = 1'b0;
        end

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // directed sequence, instance 0 also compared against fixed code words
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check_eq("d0_0_sym", 32'(out_symbol_w[0]), 32'(10'b1001110100));
        check_eq("d0_0_rd",  32'(rd_out_w[0]), 32'(1'b0));
        cycle(1'b0, 1'b1, 8'hBC, 1'b1, 1'b1);
        check_eq("k28_5_neg", 32'(out_symbol_w[0]), 32'(10'b0011111010));
        check_eq("k28_5_rd1", 32'(rd_out_w[0]), 32'(1'b1));
        cycle(1'b0, 1'b1, 8'hBC, 1'b1, 1'b1);
        check_eq("k28_5_pos", 32'(out_symbol_w[0]), 32'(10'b1100000101));
        check_eq("k28_5_rd0", 32'(rd_out_w[0]), 32'(1'b0));
        cycle(1'b0, 1'b1, 8'hF1, 1'b0, 1'b1);
        check_eq("d17_7_a7", 32'(out_symbol_w[0]), 32'(10'b1000110111));
        cycle(1'b0, 1'b1, 8'hEB, 1'b0, 1'b1);
        check_eq("d11_7_a7", 32'(out_symbol_w[0]), 32'(10'b1101001000));
        check_eq("d11_7_rd", 32'(rd_out_w[0]), 32'(1'b0));
        cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        check_eq("illk_sym", 32'(out_symbol_w[0]), 32'(10'b1001110100));
        check_eq("illk_err", 32'(out_k_err_w[0]), 32'(1'b1));
        cycle(1'b0, 1'b1, 8'hB5, 1'b0, 1'b1);
        check_eq("d21_5_sym", 32'(out_symbol_w[0]), 32'(10'b1010101010));
        check_eq("k_err_clr", 32'(out_k_err_w[0]), 32'(1'b0));
        repeat (3) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            check_eq("hold_sym",   32'(out_symbol_w[0]), 32'(10'b1010101010));
            check_eq("hold_ready", 32'(in_ready_w[0]), 32'(1'b0));
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check_eq("after_hold", 32'(out_symbol_w[0]), 32'(10'b1001110100));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("drain_vld", 32'(out_valid_w[0]), 32'(1'b0));

        // idle filler alternates between the two K28.5 forms
        prev_fill = out_symbol_w[1];
        repeat (4) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            check_eq("fill_alt", 32'(out_symbol_w[1] ^ prev_fill), 32'(10'h3FF));
            prev_fill = out_symbol_w[1];
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("rst_fill_vld", 32'(out_valid_w[1]), 32'(1'b0));
        check_eq("rst_fill_rd",  32'(rd_out_w[1]), 32'(1'b0));
        check_eq("rst_rd_init1", 32'(rd_out_w[2]), 32'(1'b1));

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd_byte = k_list[$urandom_range(0, 11)];
                rk      = 1'b1;
            end else begin
                rd_byte = 8'($urandom_range(0, 255));
                rk      = ($urandom_range(0, 4) == 0);
            end
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                  rd_byte, rk, ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
